// File: rtl/forward_hazard_ctrl.sv
// forward_hazard_ctrl: data-hazard control for a 5-stage in-order pipeline.
// Tracks shadow copies of the EX, MEM and WB stages, selects EX operand
// forwarding sources and detects load-use hazards that need a stall.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   id_*_i              ID-stage instruction fields (valid, rs1, rs2, rd,
//                       regwrite, memread)
//   flush_i             kill the ID-stage instruction (taken branch)
//   hold_i              freeze all shadow stages and the stall counter
//   fwd_a_o, fwd_b_o    operand select: 10 = EX/MEM, 01 = MEM/WB, 00 = regfile
//   stall_o             hold PC and IF/ID this cycle (combinational)
//   bubble_o            write a NOP into ID/EX this cycle (combinational)
//   stall_cnt_o         saturating count of load-use stall cycles
module forward_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic              bubble_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // EX shadow stage
    logic              ex_valid_q,    ex_valid_d;
    logic [REG_AW-1:0] ex_rs1_q,      ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q,      ex_rs2_d;
    logic [REG_AW-1:0] ex_rd_q,       ex_rd_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q,  ex_memread_d;
    // MEM shadow stage
    logic              mem_valid_q,    mem_valid_d;
    logic [REG_AW-1:0] mem_rd_q,       mem_rd_d;
    logic              mem_regwrite_q, mem_regwrite_d;
    // WB shadow stage
    logic              wb_valid_q,    wb_valid_d;
    logic [REG_AW-1:0] wb_rd_q,       wb_rd_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    // stall counter
    logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;

    logic mem_writes_rs1, mem_writes_rs2;
    logic wb_writes_rs1,  wb_writes_rs2;
    logic ex_load_rd_nz;
    logic load_use;

    // A stage writes register r only if it is live, writes, and r is not x0
    always_comb begin
        mem_writes_rs1 = mem_valid_q & mem_regwrite_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs1_q);
        mem_writes_rs2 = mem_valid_q & mem_regwrite_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs2_q);
        wb_writes_rs1  = wb_valid_q  & wb_regwrite_q  & (wb_rd_q  != '0) & (wb_rd_q  == ex_rs1_q);
        wb_writes_rs2  = wb_valid_q  & wb_regwrite_q  & (wb_rd_q  != '0) & (wb_rd_q  == ex_rs2_q);
    end

    // Forward select: MEM is the younger producer and wins over WB
    always_comb begin
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (ex_valid_q) begin
            if (mem_writes_rs1) begin
                fwd_a_o = FWD_MEM;
            end else if (wb_writes_rs1) begin
                fwd_a_o = FWD_WB;
            end
            if (mem_writes_rs2) begin
                fwd_b_o = FWD_MEM;
            end else if (wb_writes_rs2) begin
                fwd_b_o = FWD_WB;
            end
        end
    end

    // Load-use hazard; flush kills the consumer so no stall is needed.
    // Reset gating keeps stall/bubble low even if flush_i is driven in reset.
    always_comb begin
        ex_load_rd_nz = ex_valid_q & ex_memread_q & ex_regwrite_q & (ex_rd_q != '0);
        load_use      = id_valid_i & ex_load_rd_nz &
                        ((ex_rd_q == id_rs1_i) | (ex_rd_q == id_rs2_i));
        stall_o       = load_use & ~flush_i & rst_i;
        bubble_o      = (stall_o | flush_i) & rst_i;
    end

    // Next-state: shift stages unless held; a bubble loads an all-zero EX
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_rd_d        = ex_rd_q;
        ex_regwrite_d  = ex_regwrite_q;
        ex_memread_d   = ex_memread_q;
        mem_valid_d    = mem_valid_q;
        mem_rd_d       = mem_rd_q;
        mem_regwrite_d = mem_regwrite_q;
        wb_valid_d     = wb_valid_q;
        wb_rd_d        = wb_rd_q;
        wb_regwrite_d  = wb_regwrite_q;
        stall_cnt_d    = stall_cnt_q;
        if (!hold_i) begin
            wb_valid_d     = mem_valid_q;
            wb_rd_d        = mem_rd_q;
            wb_regwrite_d  = mem_regwrite_q;
            mem_valid_d    = ex_valid_q;
            mem_rd_d       = ex_rd_q;
            mem_regwrite_d = ex_regwrite_q;
            if (bubble_o) begin
                ex_valid_d    = 1'b0;
                ex_rs1_d      = '0;
                ex_rs2_d      = '0;
                ex_rd_d       = '0;
                ex_regwrite_d = 1'b0;
                ex_memread_d  = 1'b0;
            end else begin
                ex_valid_d    = id_valid_i;
                ex_rs1_d      = id_rs1_i;
                ex_rs2_d      = id_rs2_i;
                ex_rd_d       = id_rd_i;
                ex_regwrite_d = id_regwrite_i;
                ex_memread_d  = id_memread_i;
            end
            // saturate at all-ones
            if (stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_valid_q    <= mem_valid_d;
            mem_rd_q       <= mem_rd_d;
            mem_regwrite_q <= mem_regwrite_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_regwrite_q  <= wb_regwrite_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Bench for forward_hazard_ctrl: directed hazard scenarios plus randomized
// instruction streams, checked through an expectation queue against a
// history-based pipeline model. The counter is built narrow (8 bits) so
// saturation is reached in a short run.
module tb_forward_hazard_ctrl;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
    } instr_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       bu;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              id_valid_i = 1'b0;
    logic [REG_AW-1:0] id_rs1_i = '0;
    logic [REG_AW-1:0] id_rs2_i = '0;
    logic [REG_AW-1:0] id_rd_i = '0;
    logic              id_regwrite_i = 1'b0;
    logic              id_memread_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              hold_i = 1'b0;
    logic [1:0]        fwd_a_o, fwd_b_o;
    logic              stall_o, bubble_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    forward_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o),
        .bubble_o(bubble_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Model: history of what entered EX on each non-held edge (newest last)
    instr_t hist[$];
    int     cnt_m = 0;
    instr_t cur;
    logic   cur_flush, cur_hold;
    exp_t   cur_exp;
    exp_t   exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic instr_t stage(input int k);
        if (hist.size() > k) return hist[hist.size() - 1 - k];
        return '0;
    endfunction

    function automatic bit writes(input instr_t s, input logic [REG_AW-1:0] r);
        return s.v && s.rw && (s.rd == r) && (r != 0);
    endfunction

    function automatic logic [1:0] fwd_of(input logic [REG_AW-1:0] src);
        if (!stage(0).v) return 2'b00;
        if (writes(stage(1), src)) return 2'b10;
        if (writes(stage(2), src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        instr_t ex;
        ex = stage(0);
        e.fa  = fwd_of(ex.rs1);
        e.fb  = fwd_of(ex.rs2);
        e.st  = cur.v && ex.v && ex.mr && ex.rw && (ex.rd != 0) &&
                ((ex.rd == cur.rs1) || (ex.rd == cur.rs2)) && !cur_flush;
        e.bu  = e.st || cur_flush;
        e.cnt = CNT_W'(cnt_m);
        return e;
    endfunction

    // Drive one ID-stage cycle and queue the expected outputs
    task automatic present(input instr_t i, input logic fl, input logic hd);
        cur = i; cur_flush = fl; cur_hold = hd;
        id_valid_i = i.v; id_rs1_i = i.rs1; id_rs2_i = i.rs2; id_rd_i = i.rd;
        id_regwrite_i = i.rw; id_memread_i = i.mr;
        flush_i = fl; hold_i = hd;
        cur_exp = predict();
        exp_q.push_back(cur_exp);
    endtask

    // Clock edge: advance the model the way the pipeline is meant to move
    task automatic advance();
        @(posedge clk_i);
        if (!cur_hold) begin
            hist.push_back(cur_exp.bu ? instr_t'('0) : cur);
            if (hist.size() > 3) void'(hist.pop_front());
            if (cur_exp.st && cnt_m < CNT_MAX) cnt_m++;
        end
        #1;
    endtask

    function automatic instr_t mk(input logic v, input int rs1, input int rs2,
                                  input int rd, input logic rw, input logic mr);
        instr_t i;
        i.v = v; i.rs1 = REG_AW'(rs1); i.rs2 = REG_AW'(rs2); i.rd = REG_AW'(rd);
        i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        i.v   = ($urandom_range(0, 99) < 90);
        i.rs1 = REG_AW'($urandom_range(0, 7));
        i.rs2 = REG_AW'($urandom_range(0, 7));
        i.rd  = REG_AW'($urandom_range(0, 7));
        i.rw  = ($urandom_range(0, 99) < 80);
        i.mr  = ($urandom_range(0, 99) < 35);
        return i;
    endfunction

    // Monitor: compare every presented cycle against its queued expectation
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_fwd_a", 32'(fwd_a_o), 32'(e.fa));
            chk("sb_fwd_b", 32'(fwd_b_o), 32'(e.fb));
            chk("sb_stall", 32'(stall_o), 32'(e.st));
            chk("sb_bubble", 32'(bubble_o), 32'(e.bu));
            chk("sb_cnt", 32'(stall_cnt_o), 32'(e.cnt));
        end
    end

    function automatic instr_t nop();
        return mk(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endfunction

    initial begin
        instr_t r;
        logic   fl, hd;

        // reset state
        #3;
        chk("rst_fwd_a", 32'(fwd_a_o), 0);
        chk("rst_fwd_b", 32'(fwd_b_o), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_bubble", 32'(bubble_o), 0);
        chk("rst_cnt", 32'(stall_cnt_o), 0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b1;

        // ALU chain: rd=5 then rs1=5 -> MEM forward two cycles later
        present(mk(1, 1, 2, 5, 1, 0), 0, 0); #1 chk("alu_stall0", 32'(stall_o), 0); advance();
        present(mk(1, 5, 2, 1, 0, 0), 0, 0); #1 chk("alu_stall1", 32'(stall_o), 0); advance();
        present(nop(), 0, 0); #1 chk("alu_fwd_a", 32'(fwd_a_o), 32'(2'b10)); advance();

        // distance two: rd=7, unrelated, rs2=7 -> WB forward
        present(mk(1, 1, 2, 7, 1, 0), 0, 0); advance();
        present(mk(1, 1, 2, 1, 0, 0), 0, 0); advance();
        present(mk(1, 1, 7, 2, 0, 0), 0, 0); advance();
        present(nop(), 0, 0); #1 chk("dist2_fwd_b", 32'(fwd_b_o), 32'(2'b01)); advance();

        // load-use stall, consumer re-presented
        present(mk(1, 1, 2, 3, 1, 1), 0, 0); advance();
        present(mk(1, 3, 2, 1, 0, 0), 0, 0); #1
        chk("lu_stall", 32'(stall_o), 1);
        chk("lu_bubble", 32'(bubble_o), 1);
        advance();
        present(mk(1, 3, 2, 1, 0, 0), 0, 0); #1
        chk("lu_cnt", 32'(stall_cnt_o), 1);
        chk("lu_restall", 32'(stall_o), 0);
        advance();
        present(nop(), 0, 0); #1 chk("lu_fwd_a", 32'(fwd_a_o), 32'(2'b01)); advance();

        // flush with a load-use match
        present(mk(1, 1, 2, 3, 1, 1), 0, 0); advance();
        present(mk(1, 3, 2, 1, 0, 0), 1, 0); #1
        chk("fl_stall", 32'(stall_o), 0);
        chk("fl_bubble", 32'(bubble_o), 1);
        advance();
        present(nop(), 0, 0); #1 chk("fl_cnt", 32'(stall_cnt_o), 1); advance();

        // double match: MEM and WB both rd=4
        present(mk(1, 1, 2, 4, 1, 0), 0, 0); advance();
        present(mk(1, 1, 2, 4, 1, 0), 0, 0); advance();
        present(mk(1, 4, 2, 1, 0, 0), 0, 0); advance();
        present(nop(), 0, 0); #1 chk("dbl_fwd_a", 32'(fwd_a_o), 32'(2'b10)); advance();

        // hold with a pending stall
        present(mk(1, 1, 2, 6, 1, 1), 0, 0); advance();
        for (int k = 0; k < 3; k++) begin
            present(mk(1, 1, 6, 1, 0, 0), 0, 1); #1
            chk("hold_stall", 32'(stall_o), 1);
            chk("hold_cnt", 32'(stall_cnt_o), 1);
            advance();
        end
        present(mk(1, 1, 6, 1, 0, 0), 0, 0); advance();
        present(mk(1, 1, 6, 1, 0, 0), 0, 0); #1
        chk("hold_cnt_after", 32'(stall_cnt_o), 2);
        chk("hold_restall", 32'(stall_o), 0);
        advance();

        // x0 producer never forwards or stalls
        present(mk(1, 1, 2, 0, 1, 0), 0, 0); advance();
        present(mk(1, 1, 2, 0, 1, 1), 0, 0); advance();
        present(mk(1, 0, 0, 1, 0, 0), 0, 0); #1 chk("x0_stall", 32'(stall_o), 0); advance();
        present(nop(), 0, 0); #1
        chk("x0_fwd_a", 32'(fwd_a_o), 0);
        chk("x0_fwd_b", 32'(fwd_b_o), 0);
        advance();

        // random stream; stalled consumers are re-presented like real IF/ID
        r = rnd_instr();
        for (int n = 0; n < 2000; n++) begin
            fl = ($urandom_range(0, 99) < 8);
            hd = ($urandom_range(0, 99) < 12);
            present(r, fl, hd);
            advance();
            if (hd || (cur_exp.st && !hd)) r = cur;
            else r = rnd_instr();
        end

        // drive the counter into saturation
        for (int k = 0; k < 3; k++) begin present(nop(), 0, 0); advance(); end
        for (int k = 0; k < CNT_MAX + 20; k++) begin
            present(mk(1, 1, 2, 3, 1, 1), 0, 0); advance();
            present(mk(1, 3, 2, 1, 0, 0), 0, 0); advance();
            present(mk(1, 3, 2, 1, 0, 0), 0, 0); advance();
        end
        present(mk(1, 1, 2, 3, 1, 1), 0, 0); advance();
        present(mk(1, 3, 2, 1, 0, 0), 0, 0); #1
        chk("sat_stall", 32'(stall_o), 1);
        chk("sat_cnt_pre", 32'(stall_cnt_o), CNT_MAX);
        advance();
        present(nop(), 0, 0); #1 chk("sat_cnt_post", 32'(stall_cnt_o), CNT_MAX); advance();

        // mid-run asynchronous reset with live forwarding state
        present(mk(1, 1, 2, 3, 1, 1), 0, 0); advance();
        present(mk(1, 3, 3, 2, 1, 0), 0, 0); #1
        chk("pre_rst_stall", 32'(stall_o), 1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_fwd_a", 32'(fwd_a_o), 0);
        chk("arst_fwd_b", 32'(fwd_b_o), 0);
        chk("arst_stall", 32'(stall_o), 0);
        chk("arst_bubble", 32'(bubble_o), 0);
        chk("arst_cnt", 32'(stall_cnt_o), 0);
        flush_i = 1'b1;
        #1 chk("arst_flush_bubble", 32'(bubble_o), 0);
        void'(exp_q.pop_front());
        hist.delete();
        cnt_m = 0;
        @(posedge clk_i); @(posedge clk_i); #1;
        flush_i = 1'b0;
        rst_i = 1'b1;

        // first edge after release loads EX normally
        present(mk(1, 1, 2, 9, 1, 0), 0, 0); advance();
        present(mk(1, 9, 9, 1, 0, 0), 0, 0); advance();
        present(nop(), 0, 0); #1 chk("post_rst_fwd", 32'(fwd_a_o), 32'(2'b10)); advance();
        for (int n = 0; n < 200; n++) begin
            present(rnd_instr(), ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 12));
            advance();
        end

        // bounded drain of the expectation queue
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk_i);
        #1 chk("sb_drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/forward_hazard_ctrl.md
FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  asynchronous reset, active-low.
REQ-006 id_valid_i  input  1  the ID-stage instruction is valid.
REQ-007 id_rs1_i, id_rs2_i  input  REG_AW  ID-stage source registers.
REQ-008 id_rd_i  input  REG_AW  ID-stage destination register.
REQ-009 id_regwrite_i  input  1  the ID-stage instruction writes the register file.
REQ-010 id_memread_i  input  1  the ID-stage instruction is a load.
REQ-011 flush_i  input  1  kill the ID-stage instruction (taken branch).
REQ-012 hold_i  input  1  freeze the whole pipeline (external memory wait).
REQ-013 fwd_a_o, fwd_b_o  output  2  select codes for the EX-stage operand MUX32 instances: 2'b10 = EX/MEM data, 2'b01 = MEM/WB data, 2'b00 = register-file data.
REQ-014 stall_o  output  1  hold the PC and IF/ID registers for this cycle.
REQ-015 bubble_o  output  1  write a NOP into ID/EX this cycle.
REQ-016 stall_cnt_o  output  CNT_W  count of load-use stall cycles.

Function
REQ-017 The block SHALL keep three shadow stages:
- EX: valid, rs1, rs2, rd, regwrite, memread.
- MEM: valid, rd, regwrite.
- WB: valid, rd, regwrite.
REQ-018 On each edge with hold_i=0, the stages SHALL shift: WB<=MEM, MEM<=EX, EX<=ID fields.
REQ-019 When bubble_o=1, EX SHALL be loaded with valid=0 and all fields 0.
REQ-020 When hold_i=1, all shadow stages and stall_cnt_o SHALL keep their values.
REQ-021 A stage "writes rd=r" only when its valid=1, regwrite=1, rd=r and r!=0.
REQ-022 Load-use: stall_o SHALL be combinational and equal to id_valid_i & EX.valid & EX.memread & EX.regwrite & EX.rd!=0 & (EX.rd==id_rs1_i | EX.rd==id_rs2_i) & ~flush_i.
REQ-023 bubble_o SHALL equal stall_o | flush_i; flush_i has priority and suppresses stall_o.
REQ-024 fwd_a_o SHALL be combinational from the shadow stages only:
- 2'b10 if MEM writes rd=EX.rs1;
- else 2'b01 if WB writes rd=EX.rs1;
- else 2'b00.
REQ-025 fwd_b_o SHALL follow the same rule using EX.rs2.
REQ-026 When MEM and WB both match, the MEM match SHALL win (2'b10).
REQ-027 When EX.valid=0, fwd_a_o and fwd_b_o SHALL be 2'b00.
REQ-028 Forward and stall outputs SHALL remain valid during hold_i=1, reflecting the frozen stages.
REQ-029 stall_cnt_o SHALL increment by 1 on each edge with stall_o=1 and hold_i=0.
REQ-030 stall_cnt_o SHALL saturate at all-ones and SHALL NOT wrap.
REQ-031 Latency: a producer in ID at cycle n SHALL be seen for forwarding as MEM at cycle n+2 and as WB at cycle n+3, with no holds or bubbles.
REQ-032 Register x0 SHALL never generate a forward or a stall.

Reset
REQ-033 While rst_i=0, all shadow-stage fields SHALL be 0, including every valid bit.
REQ-034 While rst_i=0, stall_cnt_o SHALL be 0, fwd_a_o/fwd_b_o SHALL be 2'b00, and stall_o and bubble_o SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL clear in-flight state immediately, without waiting for a clock edge.
REQ-036 The first edge after reset release SHALL load EX normally from the ID inputs.

Verification
REQ-037 ALU chain: cycle n: rd=5, regwrite=1; cycle n+1: rs1=5 -> fwd_a_o=2'b10 at n+2, stall_o=0 throughout.
REQ-038 Distance two: producer rd=7, one unrelated instruction, then consumer rs2=7 -> fwd_b_o=2'b01 when the consumer is in EX.
REQ-039 Load-use stall:
- cycle n: load with rd=3; cycle n+1: rs1=3.
- Required: stall_o=1 and bubble_o=1 in cycle n+1, stall_cnt_o=1 after the edge.
- Consumer re-presented at n+2 -> stall_o=0 and fwd_a_o=2'b01 at n+3.
REQ-040 Flush during a stall condition:
- flush_i=1 with load-use match -> stall_o=0, bubble_o=1, stall_cnt_o unchanged.
- Double match (MEM and WB both rd=4, rs1=4) -> fwd_a_o=2'b10.
REQ-041 Hold plus x0:
- hold_i=1 for 3 cycles with a pending stall -> stages frozen, stall_o stays 1, counter does not advance.
- rd=0 producer -> fwd codes 2'b00.
REQ-042 Counter and reset:
- Preload-equivalent run to 0xFFFF plus one more stall -> stall_cnt_o stays 0xFFFF.
- Drop rst_i mid-run -> all outputs 0 asynchronously.
